// File: rtl/text_renderer.sv
// Character-cell text renderer: maps the VGA scan position to a text buffer read,
// drives the font ROM lookup, and emits RGB332 pixels with sync delayed to match.
module text_renderer #(
   parameter int         COLS         = 80,
   parameter int         ROWS         = 60,
   parameter logic [7:0] FG_COLOR     = 8'hFF,
   parameter logic [7:0] BG_COLOR     = 8'h00,
   parameter int         BLINK_FRAMES = 30,
   parameter logic       SYNC_IDLE    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [12:0] text_addr,
   input  logic [7:0]  text_char,
   output logic [7:0]  font_char,
   output logic [2:0]  font_x,
   output logic [2:0]  font_y,
   input  logic        font_pixel,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_col,
   input  logic [5:0]  cursor_row,
   output logic [7:0]  rgb,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam int               CNT_W    = $clog2(BLINK_FRAMES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [6:0]       COLS_C   = 7'(COLS);
   localparam logic [6:0]       ROWS_C   = 7'(ROWS);
   localparam logic [12:0]      COLS_A   = 13'(COLS);

   typedef enum logic {
      BLINK_OFF = 1'b0,
      BLINK_ON  = 1'b1
   } blink_state_t;

   typedef struct packed {
      logic [2:0] x_lo;
      logic [2:0] y_lo;
      logic       vis;
      logic       hs;
      logic       vs;
      logic       cur_hit;
   } stage1_t;

   localparam stage1_t STAGE1_RESET = '{
      x_lo:    3'd0,
      y_lo:    3'd0,
      vis:     1'b0,
      hs:      SYNC_IDLE,
      vs:      SYNC_IDLE,
      cur_hit: 1'b0
   };

   // ---------------------------------------------------------------------------
   // Stage 0: cell coordinates, text buffer address, cursor match
   // ---------------------------------------------------------------------------
   logic [6:0] col;
   logic [6:0] row;
   logic       in_area;
   logic       cur_hit_d;
   stage1_t    stage1_d;
   stage1_t    stage1_q;

   always_comb begin
      col       = pix_x[9:3];
      row       = pix_y[9:3];
      in_area   = (col < COLS_C) && (row < ROWS_C);
      text_addr = in_area ? (13'(row) * COLS_A + 13'(col)) : 13'd0;
      // An out-of-range cursor can never equal an in-area cell, so it stays hidden.
      cur_hit_d = cursor_en && in_area && (col == cursor_col) && (row == {1'b0, cursor_row});

      stage1_d.x_lo    = pix_x[2:0];
      stage1_d.y_lo    = pix_y[2:0];
      stage1_d.vis     = video_on && in_area;
      stage1_d.hs      = hsync_in;
      stage1_d.vs      = vsync_in;
      stage1_d.cur_hit = cur_hit_d;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage1_q <= STAGE1_RESET;
      end else begin
         stage1_q <= stage1_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: font ROM addressing (text_char arrives this cycle)
   // ---------------------------------------------------------------------------
   assign font_char = text_char;
   assign font_x    = stage1_q.x_lo;
   assign font_y    = stage1_q.y_lo;

   // ---------------------------------------------------------------------------
   // Cursor blink: frame counter advanced on vsync rising edges
   // ---------------------------------------------------------------------------
   blink_state_t     blink_state;
   blink_state_t     blink_next;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] frame_cnt_next;
   logic             vsync_prev;
   logic             vsync_rise;
   logic             blink_on;

   assign vsync_rise = vsync_in && !vsync_prev;
   assign blink_on   = (blink_state == BLINK_ON);

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_state <= BLINK_OFF;
         frame_cnt   <= '0;
         vsync_prev  <= vsync_in;
      end else begin
         blink_state <= blink_next;
         frame_cnt   <= frame_cnt_next;
         vsync_prev  <= vsync_in;
      end
   end

   // NOTE: defaults are assigned first so no path through this block can infer a latch.
   always_comb begin
      blink_next     = blink_state;
      frame_cnt_next = frame_cnt;
      if (vsync_rise) begin
         if (frame_cnt == CNT_LAST) begin
            frame_cnt_next = '0;
            blink_next     = (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
         end else begin
            frame_cnt_next = frame_cnt + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output stage: colour mapping and sync alignment
   // ---------------------------------------------------------------------------
   logic       pix;
   logic [7:0] rgb_d;

   always_comb begin
      pix   = font_pixel ^ (stage1_q.cur_hit && blink_on);
      rgb_d = stage1_q.vis ? (pix ? FG_COLOR : BG_COLOR) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb       <= 8'h00;
         hsync_out <= SYNC_IDLE;
         vsync_out <= SYNC_IDLE;
      end else begin
         rgb       <= rgb_d;
         hsync_out <= stage1_q.hs;
         vsync_out <= stage1_q.vs;
      end
   end

endmodule
